// File: rtl/vedic_mult_pipe_if.sv
`default_nettype none
//==============================================================================
// Module      : vedic_mult_pipe_if
// Description : Operand/result stream bundle for vedic_mult_pipe.
//               slave modport  - the multiplier side.
//               master modport - the producer/consumer side.
//               Signals:
//                 in_valid / in_ready  operand beat handshake
//                 in_a, in_b           WIDTH-bit unsigned operands
//                 acc_clr              restart accumulation (VEDIC_ACC_EN only)
//                 out_valid/out_ready  result handshake
//                 out_data             OW-bit result
//               Build option: VEDIC_ACC_EN adds the acc_clr signal.
// Revision    : 1.0 - initial release
//==============================================================================
interface vedic_mult_pipe_if #(
    parameter int WIDTH = 8,
    parameter int OW    = 2 * WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [OW-1:0]    out_data;

`ifdef VEDIC_ACC_EN
    logic             acc_clr;

    modport slave (
        input  in_valid, in_a, in_b, acc_clr, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_a, in_b, acc_clr, out_ready,
        input  in_ready, out_valid, out_data
    );
`else
    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_data
    );
`endif
endinterface
`default_nettype wire

// File: rtl/vedic_mult_pipe.sv
`default_nettype none
//==============================================================================
// Module      : vedic_mult_pipe (with helper vedic_mult_cell)
// Description : Two-stage pipelined unsigned Urdhva-Tiryakbhyam multiplier.
//               Operands are split into half-words; the four half-width cross
//               products are registered in stage 1 and combined into the full
//               product in stage 2. One product per clock under a valid/ready
//               stream on both sides.
//               Ports:
//                 clk    rising-edge clock
//                 rst_n  asynchronous active-low reset
//                 bus    vedic_mult_pipe_if.slave (operands in, result out)
//               Build option: VEDIC_ACC_EN - stage 2 accumulates products into
//               an ACC_W-bit register (restarted by acc_clr) and out_data
//               presents the running sum instead of the bare product.
// Revision    : 1.0 - initial release
//==============================================================================

// Combinational recursive Vedic multiplier: N x N -> 2N bits.
module vedic_mult_cell #(
    parameter int N = 2
) (
    input  wire logic [N-1:0]   i_a,
    input  wire logic [N-1:0]   i_b,
    output logic      [2*N-1:0] o_p
);
    generate
        if (N == 1) begin : g_bit
            assign o_p = {1'b0, i_a[0] & i_b[0]};
        end else if (N == 2) begin : g_leaf
            logic w_p00, w_p01, w_p10, w_p11, w_c1;
            assign w_p00 = i_a[0] & i_b[0];
            assign w_p01 = i_a[0] & i_b[1];
            assign w_p10 = i_a[1] & i_b[0];
            assign w_p11 = i_a[1] & i_b[1];
            // Vertical/crosswise: the crosswise pair is half-added; its carry
            // is then half-added into the vertical high product.
            assign w_c1  = w_p01 & w_p10;
            assign o_p   = {w_p11 & w_c1, w_p11 ^ w_c1, w_p01 ^ w_p10, w_p00};
        end else begin : g_split
            localparam int c_m = N / 2;
            logic [N-1:0]   w_ll, w_lh, w_hl, w_hh;
            logic [N:0]     w_mid;
            logic [2*N-1:0] w_mid_ext;

            vedic_mult_cell #(.N(c_m)) u_ll (.i_a(i_a[c_m-1:0]), .i_b(i_b[c_m-1:0]), .o_p(w_ll));
            vedic_mult_cell #(.N(c_m)) u_lh (.i_a(i_a[c_m-1:0]), .i_b(i_b[N-1:c_m]), .o_p(w_lh));
            vedic_mult_cell #(.N(c_m)) u_hl (.i_a(i_a[N-1:c_m]), .i_b(i_b[c_m-1:0]), .o_p(w_hl));
            vedic_mult_cell #(.N(c_m)) u_hh (.i_a(i_a[N-1:c_m]), .i_b(i_b[N-1:c_m]), .o_p(w_hh));

            assign w_mid     = {1'b0, w_lh} + {1'b0, w_hl};
            assign w_mid_ext = (2*N)'(w_mid);
            // {hh,ll} is hh<<N + ll since neither overlaps the other.
            assign o_p       = {w_hh, w_ll} + (w_mid_ext << c_m);
        end
    endgenerate
endmodule

module vedic_mult_pipe #(
    parameter int WIDTH = 8
`ifdef VEDIC_ACC_EN
    ,
    parameter int ACC_W = 2 * WIDTH + 8
`endif
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    vedic_mult_pipe_if.slave bus
);
    localparam int c_h = WIDTH / 2;

    // Whole pipeline moves together; a stalled output freezes every stage.
    logic w_en;
    logic w_accept;
    logic r_out_valid;

    assign w_en         = !r_out_valid || bus.out_ready;
    assign w_accept     = bus.in_valid && w_en;
    assign bus.in_ready = w_en;

    // Stage 1: half-width cross products.
    logic [WIDTH-1:0] w_ll, w_lh, w_hl, w_hh;
    logic [WIDTH-1:0] r_ll, r_lh, r_hl, r_hh;
    logic             r_v1;

    vedic_mult_cell #(.N(c_h)) u_ll (.i_a(bus.in_a[c_h-1:0]),     .i_b(bus.in_b[c_h-1:0]),     .o_p(w_ll));
    vedic_mult_cell #(.N(c_h)) u_lh (.i_a(bus.in_a[c_h-1:0]),     .i_b(bus.in_b[WIDTH-1:c_h]), .o_p(w_lh));
    vedic_mult_cell #(.N(c_h)) u_hl (.i_a(bus.in_a[WIDTH-1:c_h]), .i_b(bus.in_b[c_h-1:0]),     .o_p(w_hl));
    vedic_mult_cell #(.N(c_h)) u_hh (.i_a(bus.in_a[WIDTH-1:c_h]), .i_b(bus.in_b[WIDTH-1:c_h]), .o_p(w_hh));

`ifdef VEDIC_ACC_EN
    logic r_clr1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1 <= 1'b0;
            r_ll <= '0;
            r_lh <= '0;
            r_hl <= '0;
            r_hh <= '0;
`ifdef VEDIC_ACC_EN
            r_clr1 <= 1'b0;
`endif
        end else if (w_en) begin
            r_v1 <= bus.in_valid;
            if (w_accept) begin
                r_ll <= w_ll;
                r_lh <= w_lh;
                r_hl <= w_hl;
                r_hh <= w_hh;
`ifdef VEDIC_ACC_EN
                r_clr1 <= bus.acc_clr;
`endif
            end
        end
    end

    // Stage 2: combine cross products into the full 2*WIDTH product.
    logic [WIDTH:0]       w_mid;
    logic [2*WIDTH-1:0]   w_mid_ext;
    logic [2*WIDTH-1:0]   w_p;

    assign w_mid     = {1'b0, r_lh} + {1'b0, r_hl};
    assign w_mid_ext = (2*WIDTH)'(w_mid);
    assign w_p       = {r_hh, r_ll} + (w_mid_ext << c_h);

`ifdef VEDIC_ACC_EN
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_acc_base;

    assign w_acc_base = r_clr1 ? '0 : r_acc;

    // The accumulator doubles as the output register: bubbles and stalls
    // leave it untouched, which is exactly the hold behaviour of out_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_acc       <= '0;
        end else if (w_en) begin
            r_out_valid <= r_v1;
            if (r_v1) begin
                r_acc <= w_acc_base + ACC_W'(w_p);
            end
        end
    end

    assign bus.out_data = r_acc;
`else
    logic [2*WIDTH-1:0] r_out_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_en) begin
            r_out_valid <= r_v1;
            if (r_v1) begin
                r_out_data <= w_p;
            end
        end
    end

    assign bus.out_data = r_out_data;
`endif

    assign bus.out_valid = r_out_valid;
endmodule
`default_nettype wire
